// File: rtl/mux_gate_arbiter_pkg.sv
// Shared opcodes, FSM states and the mux2 primitive for the gate arbiter.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package mux_gate_arbiter_pkg;

  localparam int OPW = 3;

  localparam logic [OPW-1:0] OP_BUF  = 3'd0;
  localparam logic [OPW-1:0] OP_NOT  = 3'd1;
  localparam logic [OPW-1:0] OP_AND  = 3'd2;
  localparam logic [OPW-1:0] OP_OR   = 3'd3;
  localparam logic [OPW-1:0] OP_NAND = 3'd4;
  localparam logic [OPW-1:0] OP_NOR  = 3'd5;
  localparam logic [OPW-1:0] OP_XOR  = 3'd6;
  localparam logic [OPW-1:0] OP_XNOR = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Data inputs of one mux2 cell: d0 is taken when a=0, d1 when a=1.
  typedef struct packed {
    logic d0;
    logic d1;
  } mux_in_t;

  // The single gate primitive: a 2x1 multiplexer.
  function automatic logic mux2(input logic sel, input logic d0, input logic d1);
    return sel ? d1 : d0;
  endfunction

  // Every 2-input gate g(a,b) is a mux on a with legs g(0,b) and g(1,b),
  // each of which is one of b, ~b, 0 or 1.
  function automatic mux_in_t mux_legs(input logic [OPW-1:0] op, input logic b);
    mux_in_t m;
    case (op)
      OP_BUF:  m = '{d0: 1'b0, d1: 1'b1};
      OP_NOT:  m = '{d0: 1'b1, d1: 1'b0};
      OP_AND:  m = '{d0: 1'b0, d1: b};
      OP_OR:   m = '{d0: b,    d1: 1'b1};
      OP_NAND: m = '{d0: 1'b1, d1: ~b};
      OP_NOR:  m = '{d0: ~b,   d1: 1'b0};
      OP_XOR:  m = '{d0: b,    d1: ~b};
      default: m = '{d0: ~b,   d1: b};   // OP_XNOR
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mux_gate_unit.sv
// Bitwise logic unit built only from 2x1 muxes selected by operand a.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the arbiter registers the output.
module mux_gate_unit
  import mux_gate_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  mux_in_t w_legs [WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign w_legs[i] = mux_legs(op, b[i]);
    assign y[i]      = mux2(a[i], w_legs[i].d0, w_legs[i].d1);
  end

endmodule

// File: rtl/mux_gate_arbiter.sv
// Round-robin arbiter sharing one mux gate unit among N_REQ requesters.
// Latency: gnt the cycle after acceptance, done/y one cycle later; one op per 3 cycles.
// Backpressure: requests are levels; losers stay pending until granted.
module mux_gate_arbiter
  import mux_gate_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [OPW*N_REQ-1:0]   op,
  input  logic [WIDTH*N_REQ-1:0] a,
  input  logic [WIDTH*N_REQ-1:0] b,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic [WIDTH-1:0]       y,
  output logic                   busy
);

  localparam int PW = $clog2(N_REQ);
  localparam logic [PW:0]   N_EXT = (PW+1)'(N_REQ);
  localparam logic [PW-1:0] LAST  = PW'(N_REQ - 1);

  state_t           r_state, w_state_nxt;
  logic [PW-1:0]    r_ptr, w_ptr_nxt;
  logic [PW-1:0]    r_win, w_win_nxt;
  logic [OPW-1:0]   r_op, w_op_nxt;
  logic [WIDTH-1:0] r_a, w_a_nxt;
  logic [WIDTH-1:0] r_b, w_b_nxt;
  logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [N_REQ-1:0] r_done, w_done_nxt;
  logic [WIDTH-1:0] r_y, w_y_nxt;
  logic             r_busy;

  logic             w_found;
  logic [PW-1:0]    w_pick;
  logic [PW:0]      w_sum;
  logic [OPW-1:0]   w_sel_op;
  logic [WIDTH-1:0] w_sel_a, w_sel_b;
  logic [WIDTH-1:0] w_gate_y;

  // Search from the rr pointer upward, wrapping, for the first pending request.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_sum   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_sum >= N_EXT) w_sum = w_sum - N_EXT;
      if (!w_found && req[w_sum[PW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_sum[PW-1:0];
      end
    end
  end

  // Route the winner's opcode and operands toward the latches.
  always_comb begin
    w_sel_op = '0;
    w_sel_a  = '0;
    w_sel_b  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_pick == PW'(i)) begin
        w_sel_op = op[OPW*i +: OPW];
        w_sel_a  = a[WIDTH*i +: WIDTH];
        w_sel_b  = b[WIDTH*i +: WIDTH];
      end
    end
  end

  mux_gate_unit #(.WIDTH(WIDTH)) u_gate (
    .op (r_op),
    .a  (r_a),
    .b  (r_b),
    .y  (w_gate_y)
  );

  // Next-state and output decode for IDLE -> EXEC -> DONE -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_win_nxt   = r_win;
    w_op_nxt    = r_op;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_gnt_nxt   = '0;
    w_done_nxt  = '0;
    w_y_nxt     = r_y;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_win_nxt   = w_pick;
          w_op_nxt    = w_sel_op;
          w_a_nxt     = w_sel_a;
          w_b_nxt     = w_sel_b;
          w_gnt_nxt   = N_REQ'(1) << w_pick;
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_y_nxt     = w_gate_y;
        w_done_nxt  = N_REQ'(1) << r_win;
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_ptr_nxt   = (r_win == LAST) ? '0 : r_win + PW'(1);
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, pointer, operand latches and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_win   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_y     <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_win   <= w_win_nxt;
      r_op    <= w_op_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_gnt   <= w_gnt_nxt;
      r_done  <= w_done_nxt;
      r_y     <= w_y_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  assign gnt  = r_gnt;
  assign done = r_done;
  assign y    = r_y;
  assign busy = r_busy;

endmodule

// File: tb/tb_mux_gate_arbiter.sv
// Scoreboard bench for mux_gate_arbiter with a round-robin reference model.
// Latency: expects gnt one cycle after acceptance and done/y one cycle after gnt.
// Backpressure: requesters hold req until granted, then drop it.
module tb_mux_gate_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [3*N-1:0] op = '0;
  logic [W*N-1:0] a = '0;
  logic [W*N-1:0] b = '0;
  logic [N-1:0]   gnt, done;
  logic [W-1:0]   y;
  logic           busy;

  mux_gate_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .op    (op),
    .a     (a),
    .b     (b),
    .gnt   (gnt),
    .done  (done),
    .y     (y),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] oh;
    logic [W-1:0] y;
  } exp_t;

  exp_t         q_gnt[$];
  exp_t         q_done[$];
  int           tests = 0;
  int           fails = 0;

  // Requester-side view: pending set and each requester's held operation.
  logic [N-1:0] pend = '0;
  logic [2:0]   p_op[N];
  logic [W-1:0] p_a[N];
  logic [W-1:0] p_b[N];
  int           ptr_m = 0;
  logic [W-1:0] last_y = '0;
  logic [N-1:0] prev_gnt = '0;
  bit           mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_f(input logic [2:0] o, input logic [W-1:0] x,
                                         input logic [W-1:0] z);
    case (o)
      3'd0: return x;
      3'd1: return ~x;
      3'd2: return x & z;
      3'd3: return x | z;
      3'd4: return ~(x & z);
      3'd5: return ~(x | z);
      3'd6: return x ^ z;
      default: return ~(x ^ z);
    endcase
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      op[3*i +: 3] = p_op[i];
      a[W*i +: W]  = p_a[i];
      b[W*i +: W]  = p_b[i];
    end
    req = pend;
  endtask

  // One arbitration round, entered just after a negedge with the DUT idle.
  task automatic round(input logic [N-1:0] add, input bit rnd);
    int   w;
    exp_t e;
    for (int i = 0; i < N; i++) begin
      if (add[i] && !pend[i]) begin
        pend[i] = 1'b1;
        if (rnd) begin
          p_op[i] = 3'($urandom_range(0, 7));
          p_a[i]  = W'($urandom);
          p_b[i]  = W'($urandom);
        end
      end
    end
    drive();
    if (pend == '0) begin
      @(negedge clk);
      return;
    end
    w = -1;
    for (int k = 0; k < N; k++)
      if (w < 0 && pend[(ptr_m + k) % N]) w = (ptr_m + k) % N;
    e.oh = N'(1) << w;
    e.y  = ref_f(p_op[w], p_a[w], p_b[w]);
    q_gnt.push_back(e);
    q_done.push_back(e);
    @(posedge clk);
    #1;
    // Winner saw gnt: drop its request and scribble its operands.
    pend[w] = 1'b0;
    p_op[w] = 3'($urandom);
    p_a[w]  = W'($urandom);
    p_b[w]  = W'($urandom);
    drive();
    ptr_m = (w + 1) % N;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: compares every presented gnt/done against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      chk("busy", {31'b0, busy}, {31'b0, (gnt != '0) || (done != '0)});
      if (gnt != '0) begin
        if (q_gnt.size() == 0) chk("unexpected_gnt", 32'(gnt), 32'd0);
        else begin
          e = q_gnt.pop_front();
          chk("gnt", 32'(gnt), 32'(e.oh));
        end
      end
      if (done != '0) begin
        chk("done_after_gnt", 32'(done), 32'(prev_gnt));
        if (q_done.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
        else begin
          e = q_done.pop_front();
          chk("done", 32'(done), 32'(e.oh));
          chk("y", 32'(y), 32'(e.y));
          last_y = e.y;
        end
      end else begin
        chk("y_hold", 32'(y), 32'(last_y));
      end
      prev_gnt = gnt;
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      p_op[i] = '0;
      p_a[i]  = '0;
      p_b[i]  = '0;
    end
    // Reset state.
    #12;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Idle with operand churn: nothing may move.
    for (int c = 0; c < 20; c++) begin
      a  = (W*N)'({$urandom, $urandom});
      b  = (W*N)'({$urandom, $urandom});
      op = (3*N)'($urandom);
      @(negedge clk);
    end
    for (int i = 0; i < N; i++) begin
      p_op[i] = 3'(op[3*i +: 3]);
      p_a[i]  = a[W*i +: W];
      p_b[i]  = b[W*i +: W];
    end

    // Single AND on requester 0.
    p_op[0] = 3'd2; p_a[0] = 8'hF0; p_b[0] = 8'h3C;
    round(4'b0001, 1'b0);

    // All opcodes on requester 1.
    for (int k = 0; k < 8; k++) begin
      p_op[1] = 3'(k); p_a[1] = 8'hAA; p_b[1] = 8'hCC;
      round(4'b0010, 1'b0);
    end

    // All four at once.
    for (int i = 0; i < N; i++) begin
      p_op[i] = 3'($urandom); p_a[i] = W'($urandom); p_b[i] = W'($urandom);
    end
    round(4'b1111, 1'b0);
    for (int k = 0; k < 3; k++) round(4'b0000, 1'b0);

    // Requesters 0 and 2 continuously for 12 grants.
    for (int k = 0; k < 12; k++) round(4'b0101, 1'b1);
    while (pend != '0) round(4'b0000, 1'b0);

    // Park the pointer away from 0, then reset mid-EXEC.
    round(4'b0100, 1'b1);
    p_op[1] = 3'd6; p_a[1] = 8'h5A; p_b[1] = 8'h0F;
    pend = 4'b0010;
    drive();
    @(posedge clk);
    #1;
    chk("t5_gnt_before_rst", 32'(gnt), 32'b0010);
    pend = '0;
    drive();
    rst_n = 1'b0;
    last_y = '0;
    ptr_m  = 0;
    #1;
    chk("t5_gnt", 32'(gnt), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_y", 32'(y), 32'd0);
    chk("t5_busy", {31'b0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    round(4'b1001, 1'b1);   // pointer back at 0 picks requester 0
    while (pend != '0) round(4'b0000, 1'b0);
    round(4'b0010, 1'b1);

    // Randomized traffic.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 5) == 0) round(4'b0000, 1'b1);
      else round(N'($urandom) & N'($urandom | $urandom), 1'b1);
    end
    while (pend != '0) round(4'b0000, 1'b0);

    repeat (4) @(negedge clk);
    chk("gnt_queue_empty", 32'(q_gnt.size()), 32'd0);
    chk("done_queue_empty", 32'(q_done.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
